// File: rtl/snake_pkg.sv
// Shared types for the snakes game: FSM states, heading and key codes, and
// the reverse-direction helper used by the direction arbiter.
package snake_pkg;

  typedef enum logic [2:0] {
    ST_MENU   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_PLAY   = 3'd2,
    ST_PAUSED = 3'd3,
    ST_DYING  = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  localparam logic [1:0] HD_UP    = 2'b00;
  localparam logic [1:0] HD_LEFT  = 2'b01;
  localparam logic [1:0] HD_DOWN  = 2'b10;
  localparam logic [1:0] HD_RIGHT = 2'b11;

  localparam logic [4:0] KEY_UP    = 5'b00010;
  localparam logic [4:0] KEY_LEFT  = 5'b00100;
  localparam logic [4:0] KEY_DOWN  = 5'b01000;
  localparam logic [4:0] KEY_RIGHT = 5'b10000;

  // Heading codes are laid out so that the reverse differs only in the MSB.
  function automatic logic [1:0] opposite(input logic [1:0] hd);
    return hd ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_step_timer.sv
// Frame divider plus frame-per-step counter. Freezing `run` holds every bit
// of phase, including a frame tick that has fired but not yet been counted.
module snake_step_timer
  import snake_pkg::*;
#(
  parameter int TICK_DIV        = 840000,
  parameter int FRAMES_PER_STEP = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  input  logic clear,
  input  logic tick,
  output logic frame_tick,
  output logic step
);

  localparam int CW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CW-1:0] DIV_MAX  = CW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(FRAMES_PER_STEP - 1);

  logic [CW-1:0] div_cnt_r;
  logic [SW-1:0] step_cnt_r;
  logic          frame_tick_r;
  logic          advance_s;

  // `tick` gates step counting so frame ticks can still drive the death flash.
  assign advance_s  = run & tick & frame_tick_r;
  assign frame_tick = frame_tick_r;
  assign step       = advance_s & (step_cnt_r == STEP_MAX);

  // Frame divider: count down, fire one tick at zero, reload.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_cnt_r    <= DIV_MAX;
      frame_tick_r <= 1'b0;
    end else if (clear) begin
      div_cnt_r    <= DIV_MAX;
      frame_tick_r <= 1'b0;
    end else if (run) begin
      frame_tick_r <= (div_cnt_r == CW'(0));
      div_cnt_r    <= (div_cnt_r == CW'(0)) ? DIV_MAX : div_cnt_r - CW'(1);
    end
  end

  // Step counter: frame ticks modulo FRAMES_PER_STEP.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step_cnt_r <= SW'(0);
    end else if (clear) begin
      step_cnt_r <= SW'(0);
    end else if (advance_s) begin
      step_cnt_r <= (step_cnt_r == STEP_MAX) ? SW'(0) : step_cnt_r + SW'(1);
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Game sequencing for the snakes design: top FSM, direction arbitration and
// size/score bookkeeping around the snake step timer. All outputs registered.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_DIV        = 840000,
  parameter int FRAMES_PER_STEP = 3,
  parameter int MAX_LEN         = 640,
  parameter int INIT_LEN        = 1,
  parameter int GROW            = 5,
  parameter int FLASH_FRAMES    = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       pause,
  input  logic [4:0] direction,
  input  logic       eat,
  input  logic       hit,
  output logic       inmenu,
  output logic       ingame,
  output logic       clr_we,
  output logic [9:0] clr_addr,
  output logic       step,
  output logic [1:0] heading,
  output logic [9:0] size,
  output logic [9:0] score,
  output logic       apple_respawn,
  output logic       flash,
  output logic       game_over
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam logic [9:0]    LEN_MAX    = 10'(MAX_LEN);
  localparam logic [9:0]    LEN_INIT   = 10'(INIT_LEN);
  localparam logic [10:0]   GROW_W     = 11'(GROW);
  localparam logic [9:0]    SCORE_MAX  = 10'd1023;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

  state_e        state_r, state_n;
  logic [9:0]    clr_addr_r, size_r, score_r;
  logic [1:0]    heading_r, pend_dir_r, key_dir_s;
  logic          pend_vld_r, key_vld_s;
  logic [FW-1:0] flash_cnt_r;
  logic          flash_r, step_r, respawn_r, inmenu_r, ingame_r, clr_we_r, game_over_r;
  logic          flash_n, inmenu_n, ingame_n, clr_we_n, game_over_n;
  logic          frame_tick_s, step_s, timer_run_s, timer_clr_s, timer_tick_s;
  logic          eat_ok_s, dying_tick_s, new_game_s, steer_s;
  logic [10:0]   size_sum_s;

  assign timer_run_s  = (state_r == ST_PLAY) || (state_r == ST_DYING);
  assign timer_tick_s = (state_r == ST_PLAY);
  assign timer_clr_s  = (state_r == ST_CLEAR);

  snake_step_timer #(
    .TICK_DIV        (TICK_DIV),
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .run        (timer_run_s),
    .clear      (timer_clr_s),
    .tick       (timer_tick_s),
    .frame_tick (frame_tick_s),
    .step       (step_s)
  );

  assign eat_ok_s     = (state_r == ST_PLAY) && eat && !hit;
  assign dying_tick_s = (state_r == ST_DYING) && frame_tick_s;
  assign new_game_s   = (state_r == ST_MENU) && start;
  assign steer_s      = (state_r == ST_PLAY) || (state_r == ST_PAUSED);
  assign size_sum_s   = {1'b0, size_r} + GROW_W;

  // Key-code decode; anything other than the four codes is no request.
  always_comb begin
    key_vld_s = 1'b1;
    key_dir_s = HD_UP;
    case (direction)
      KEY_UP:    key_dir_s = HD_UP;
      KEY_LEFT:  key_dir_s = HD_LEFT;
      KEY_DOWN:  key_dir_s = HD_DOWN;
      KEY_RIGHT: key_dir_s = HD_RIGHT;
      default:   key_vld_s = 1'b0;
    endcase
  end

  // Next-state logic and next values of the registered mode outputs.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_MENU:   if (start) state_n = ST_CLEAR; else state_n = ST_MENU;
      ST_CLEAR:  if (clr_addr_r == LEN_MAX) state_n = ST_PLAY; else state_n = ST_CLEAR;
      ST_PLAY: begin
        if (hit)        state_n = ST_DYING;
        else if (pause) state_n = ST_PAUSED;
        else            state_n = ST_PLAY;
      end
      ST_PAUSED: if (pause) state_n = ST_PLAY; else state_n = ST_PAUSED;
      ST_DYING: begin
        if (dying_tick_s && (flash_cnt_r == FLASH_LAST)) state_n = ST_OVER;
        else                                             state_n = ST_DYING;
      end
      ST_OVER:   if (start) state_n = ST_MENU; else state_n = ST_OVER;
      default:   state_n = ST_MENU;
    endcase
    inmenu_n    = (state_n == ST_MENU);
    ingame_n    = (state_n == ST_PLAY) || (state_n == ST_PAUSED) ||
                  (state_n == ST_DYING) || (state_n == ST_OVER);
    clr_we_n    = (state_n == ST_CLEAR);
    game_over_n = (state_n == ST_OVER);
    if (state_n == ST_OVER)                                flash_n = 1'b1;
    else if ((state_n == ST_DYING) && (state_r == ST_DYING)) flash_n = flash_r ^ dying_tick_s;
    else                                                   flash_n = 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= ST_MENU;
    else         state_r <= state_n;
  end

  // Registered mode, strobe and flash outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inmenu_r    <= 1'b1;
      ingame_r    <= 1'b0;
      clr_we_r    <= 1'b0;
      game_over_r <= 1'b0;
      flash_r     <= 1'b0;
      step_r      <= 1'b0;
      respawn_r   <= 1'b0;
      clr_addr_r  <= 10'd0;
      flash_cnt_r <= FW'(0);
    end else begin
      inmenu_r    <= inmenu_n;
      ingame_r    <= ingame_n;
      clr_we_r    <= clr_we_n;
      game_over_r <= game_over_n;
      flash_r     <= flash_n;
      step_r      <= step_s;
      respawn_r   <= eat_ok_s;
      if (state_n == ST_CLEAR) clr_addr_r <= (state_r == ST_CLEAR) ? clr_addr_r + 10'd1 : 10'd1;
      else                     clr_addr_r <= 10'd0;
      if (state_r != ST_DYING) flash_cnt_r <= FW'(0);
      else if (dying_tick_s)   flash_cnt_r <= flash_cnt_r + FW'(1);
    end
  end

  // Game bookkeeping: new-game load, growth/score, pending direction, heading.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      size_r     <= LEN_INIT;
      score_r    <= 10'd0;
      heading_r  <= HD_RIGHT;
      pend_vld_r <= 1'b0;
      pend_dir_r <= HD_UP;
    end else if (new_game_s) begin
      size_r     <= LEN_INIT;
      score_r    <= 10'd0;
      heading_r  <= HD_RIGHT;
      pend_vld_r <= 1'b0;
      pend_dir_r <= HD_UP;
    end else begin
      if (eat_ok_s) begin
        size_r  <= (size_sum_s > {1'b0, LEN_MAX}) ? LEN_MAX : size_sum_s[9:0];
        score_r <= (score_r == SCORE_MAX) ? score_r : score_r + 10'd1;
      end
      // A request arriving on a step edge survives for the following step.
      if (steer_s && key_vld_s) begin
        pend_vld_r <= 1'b1;
        pend_dir_r <= key_dir_s;
      end else if (step_s) begin
        pend_vld_r <= 1'b0;
      end
      if (step_s && pend_vld_r && (pend_dir_r != opposite(heading_r))) heading_r <= pend_dir_r;
    end
  end

  assign inmenu        = inmenu_r;
  assign ingame        = ingame_r;
  assign clr_we        = clr_we_r;
  assign clr_addr      = clr_addr_r;
  assign step          = step_r;
  assign heading       = heading_r;
  assign size          = size_r;
  assign score         = score_r;
  assign apple_respawn = respawn_r;
  assign flash         = flash_r;
  assign game_over     = game_over_r;

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-sequencing controller for the snakes design. It owns the top-level game FSM (menu, board clear, play, pause, death flash, game over) and drives the snake `datapath` mode inputs. It generates the snake step strobe and arbitrates keyboard direction requests under the no-reverse rule. It also tracks snake length and score from the collision pulses the datapath reports back, and sits between `kbInput` and `datapath` in `snakes`.

## Interface
Parameters:
- `TICK_DIV`, 840000: `clk` cycles per frame tick.
- `FRAMES_PER_STEP`, 3: frame ticks per snake step.
- `MAX_LEN`, 640: highest body index; also the size ceiling.
- `INIT_LEN`, 1: size after clear.
- `GROW`, 5: size increment per apple.
- `FLASH_FRAMES`, 30: frame ticks spent in DYING.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `resetn`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse, pre-debounced.
- `pause`  in  1  one-cycle pulse, toggles pause.
- `direction`  in  5  key code: 00010 up, 00100 left, 01000 down, 10000 right; other values mean no request.
- `eat`  in  1  good-collision pulse from datapath.
- `hit`  in  1  bad-collision pulse from datapath.
- `inmenu`  out  1  datapath menu mode.
- `ingame`  out  1  datapath game mode.
- `clr_we`  out  1  body-memory clear write enable.
- `clr_addr`  out  10  body index being cleared.
- `step`  out  1  one-cycle strobe: advance snake one cell.
- `heading`  out  2  00 up, 01 left, 10 down, 11 right.
- `size`  out  10  current snake length.
- `score`  out  10  apples eaten.
- `apple_respawn`  out  1  one-cycle strobe: relocate apple.
- `flash`  out  1  death flash colour enable.
- `game_over`  out  1  high in OVER.

## Operation
- States: MENU, CLEAR, PLAY, PAUSED, DYING, OVER.
- MENU: `inmenu`=1. On `start` go to CLEAR.
- CLEAR: `clr_we`=1 and `clr_addr` steps 1..MAX_LEN, one index per cycle (MAX_LEN cycles). On entry, load size=INIT_LEN, score=0, heading=11, pending request=none, and zero both timers. After `clr_addr`==MAX_LEN is written, go to PLAY.
- PLAY: `ingame`=1. The frame/step timers run.
  - `pause` goes to PAUSED.
  - `hit` goes to DYING.
  - `eat`: size += GROW, saturating at MAX_LEN; score += 1, saturating at 1023; `apple_respawn` pulses the next cycle.
- PAUSED: `ingame`=1, timers frozen, `eat`/`hit` ignored. `pause` returns to PLAY and timers resume from their held values.
- DYING: `ingame`=1, no steps. `flash` toggles on every frame tick. After FLASH_FRAMES ticks go to OVER.
- OVER: `game_over`=1, `flash`=1, `ingame`=1. On `start` go to MENU.
- Direction arbitration:
  - A valid `direction` code in PLAY or PAUSED overwrites a 1-entry pending register; the latest request wins.
  - At each `step`, pending is applied unless it is the exact reverse of `heading`, then pending is cleared.
  - Invalid codes are ignored.
- Simultaneous events:
  - `hit` and `eat` in the same cycle: `hit` wins, no growth, no score.
  - `pause` and `hit` in the same cycle: `hit` wins.
  - `start` outside MENU/OVER is ignored.
- `eat`/`hit` outside PLAY are ignored.

## Timing
- Reset (async assert, sync release) gives:
  - state MENU, `inmenu`=1, `ingame`=0.
  - `step`=`clr_we`=`apple_respawn`=`flash`=`game_over`=0.
  - `clr_addr`=0, `heading`=11, `size`=INIT_LEN, `score`=0.
- Reset mid-game returns to MENU immediately; no partial CLEAR resumes.
- All outputs are registered; a state change is visible the cycle after the triggering input edge.
- Frame counter: TICK_DIV-1 down to 0, then the tick fires for one cycle and the counter reloads.
- Step counter: counts ticks 0..FRAMES_PER_STEP-1. `step` is asserted in the cycle after the tick on which the count wraps.
- `heading` updates on the same edge that raises `step`, so the datapath sees the new heading while `step`=1.
- First `step` after entering PLAY: TICK_DIV×FRAMES_PER_STEP + 1 cycles.
- `size`/`score` update on the edge after `eat`, and `apple_respawn` is high in that same cycle.

## Structure
- Shared package `snake_pkg`: state enum, heading codes, direction key codes, `opposite()` function.
- Sub-module `snake_step_timer`: frame divider plus step counter, with `run`, `clear` and `tick` inputs and `frame_tick` and `step` outputs. The FSM and arbitration live in the top level.

## Test plan
All scenarios use TICK_DIV=4, FRAMES_PER_STEP=3, MAX_LEN=8, GROW=5, FLASH_FRAMES=2.
- Reset then `start` -> CLEAR: 8 cycles of `clr_we`, `clr_addr` 1..8; then PLAY with size=1, score=0, heading=11.
- In PLAY, no input -> `step` period is exactly 12 cycles; first `step` 13 cycles after PLAY entry.
- `direction`=00100 (left) while heading right -> ignored at next step, heading stays 11. Then 00010 followed by 01000 before a step -> heading=10 at that step.
- `eat` twice -> size 1→6→8 (saturated), score=2, two `apple_respawn` pulses. `eat`+`hit` in the same cycle -> DYING with size and score unchanged.
- `pause` -> no `step` for 100 cycles and `eat` ignored; `pause` again -> next `step` lands at the held timer phase.
- `hit` -> DYING: `flash` toggles on 2 frame ticks, then OVER (`game_over`=1); `start` -> MENU. `resetn` low during CLEAR -> MENU with all reset values.
